// File: rtl/stdcore_vrser.sv
// Val/rdy width-down serializer: one wide word of up to N beats in, DW-bit beats out,
// beat 0 first, with a last-beat marker. Synchronous active-high reset.
module stdcore_vrser #(
  parameter int unsigned DW = 8,
  parameter int unsigned N  = 4,
  parameter int unsigned LW = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N*DW-1:0] p_i,
  input  logic [LW-1:0]   p_len_i,
  input  logic            p_val_i,
  output logic            p_rdy_o,
  output logic [DW-1:0]   c_o,
  output logic            c_last_o,
  output logic            c_val_o,
  input  logic            c_rdy_i
);

  logic [N*DW-1:0] hold_q, hold_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   len_q, len_d;
  logic            busy_q, busy_d;

  logic [LW-1:0]   eff_len;
  logic            accept;
  logic            xfer;

  // Lengths of 0 or beyond N saturate to a full word.
  always_comb begin
    if ((p_len_i == '0) || (p_len_i > LW'(N))) begin
      eff_len = LW'(N);
    end else begin
      eff_len = p_len_i;
    end
  end

  always_comb begin
    c_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx_q == LW'(k)) begin
        c_o = hold_q[k*DW +: DW];
      end
    end
  end

  assign c_val_o  = busy_q;
  assign c_last_o = busy_q && (idx_q == (len_q - LW'(1)));
  assign p_rdy_o  = !rst_i && (!busy_q || (c_rdy_i && c_last_o));
  assign accept   = p_val_i && p_rdy_o;
  assign xfer     = c_val_o && c_rdy_i;

  // An accept while busy can only coincide with the last-beat transfer, so a reload
  // takes priority over the idx/busy update.
  always_comb begin
    hold_d = hold_q;
    idx_d  = idx_q;
    len_d  = len_q;
    busy_d = busy_q;
    if (accept) begin
      hold_d = p_i;
      idx_d  = '0;
      len_d  = eff_len;
      busy_d = 1'b1;
    end else if (xfer) begin
      if (c_last_o) begin
        busy_d = 1'b0;
      end else begin
        idx_d = idx_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
      idx_q  <= '0;
      len_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_stdcore_vrser.sv
// Bench for stdcore_vrser: directed steps plus random traffic checked against a
// queue-of-beats reference model.
module tb_stdcore_vrser;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned LW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] p;
  logic [LW-1:0]   p_len;
  logic            p_val;
  logic            p_rdy;
  logic [DW-1:0]   c;
  logic            c_last;
  logic            c_val;
  logic            c_rdy;

  stdcore_vrser #(.DW(DW), .N(N), .LW(LW)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .p_i      (p),
    .p_len_i  (p_len),
    .p_val_i  (p_val),
    .p_rdy_o  (p_rdy),
    .c_o      (c),
    .c_last_o (c_last),
    .c_val_o  (c_val),
    .c_rdy_i  (c_rdy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: beats still owed for the word in flight, front = current beat.
  logic [DW-1:0] exp_beats[$];
  bit            fresh = 1'b1;
  int            n_xfer = 0;
  int            n_acc = 0;
  int            sum_len = 0;
  int            bubbles = 0;
  bit            streaming = 1'b0;

  function automatic int eff(input logic [LW-1:0] l);
    if (l == 0 || int'(l) > int'(N)) return int'(N);
    return int'(l);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check 1ns later, then advance the model.
  task automatic cycle(input logic r, input logic pv, input logic [N*DW-1:0] pd,
                       input logic [LW-1:0] pl, input logic cr);
    logic ev;
    logic ep;
    int   len;
    @(negedge clk);
    rst   = r;
    p_val = pv;
    p     = pd;
    p_len = pl;
    c_rdy = cr;
    #1;
    ev = exp_beats.size() > 0;
    ep = !r && (!ev || (cr && exp_beats.size() == 1));
    chk("p_rdy", 32'(p_rdy), 32'(ep));
    chk("c_val", 32'(c_val), 32'(ev));
    chk("c_last", 32'(c_last), 32'(ev && exp_beats.size() == 1));
    if (ev) chk("c_beat", 32'(c), 32'(exp_beats[0]));
    else if (fresh) chk("c_zero", 32'(c), 32'(0));
    if (c_val === 1'b1 && cr) n_xfer++;
    if (streaming && c_val !== 1'b1) bubbles++;
    if (r) begin
      exp_beats.delete();
      fresh = 1'b1;
    end else begin
      if (ev && cr) void'(exp_beats.pop_front());
      if (pv && ep) begin
        n_acc++;
        len = eff(pl);
        sum_len += len;
        for (int k = 0; k < len; k++) exp_beats.push_back(pd[k*DW +: DW]);
        fresh = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_beats.size() > 0; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1);
    chk("drain_empty", 32'(exp_beats.size()), 32'(0));
  endtask

  logic [N*DW-1:0] w;
  logic            cr_pat [7];
  int              a0;
  int              x0;
  int              s0;

  initial begin
    rst   = 1'b1;
    p_val = 1'b1;
    p     = '0;
    p_len = '0;
    c_rdy = 1'b1;
    @(posedge clk);

    // Reset held with p_val high: nothing accepted, outputs quiet.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'hDEADBEEF, 3'd4, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b0);
    chk("idle_no_word", 32'(n_acc), 32'(0));

    // Full word.
    cycle(1'b0, 1'b1, 32'h44332211, 3'd4, 1'b1);
    drain();

    // Short word and length saturation.
    cycle(1'b0, 1'b1, 32'h123456AA, 3'd1, 1'b1);
    drain();
    cycle(1'b0, 1'b1, 32'hA1B2C3D4, 3'd0, 1'b1);
    drain();
    cycle(1'b0, 1'b1, 32'h0F1E2D3C, 3'd7, 1'b1);
    drain();

    // Back-pressure; a second word waits until the last-beat transfer.
    cycle(1'b0, 1'b1, 32'h44332211, 3'd4, 1'b1);
    cr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    x0 = n_xfer;
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 32'h88776655, 3'd2, cr_pat[i]);
    chk("bp_xfers", 32'(n_xfer - x0), 32'(4));
    drain();

    // Back-to-back streaming of 100 random words.
    a0 = n_acc;
    x0 = n_xfer;
    s0 = sum_len;
    cycle(1'b0, 1'b1, $urandom(), 3'($urandom_range(0, 7)), 1'b1);
    streaming = 1'b1;
    bubbles   = 0;
    for (int i = 0; i < 1000 && (n_acc - a0) < 100; i++) begin
      cycle(1'b0, 1'b1, $urandom(), 3'($urandom_range(0, 7)), 1'b1);
    end
    streaming = 1'b0;
    drain();
    chk("stream_words", 32'(n_acc - a0), 32'(100));
    chk("stream_bubbles", 32'(bubbles), 32'(0));
    chk("stream_beats", 32'(n_xfer - x0), 32'(sum_len - s0));

    // Reset mid-word after beat 1.
    cycle(1'b0, 1'b1, 32'hDDCCBBAA, 3'd4, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    x0 = n_xfer;
    cycle(1'b1, 1'b1, 32'h99999999, 3'd4, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    chk("rst_mid_no_beats", 32'(n_xfer - x0), 32'(0));
    cycle(1'b0, 1'b1, 32'h04030201, 3'd4, 1'b1);
    drain();

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      w = $urandom();
      cycle(1'b0, 1'($urandom_range(0, 1)), w, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stdcore_vrser.md
# stdcore_vrser

Val/rdy width-down serializer: accepts one wide word of up to N beats on the producer side and emits it as a sequence of DW-bit beats on the consumer side, with a last-beat marker. It is the transmit-side counterpart of the stdcore ready-FIFOs. It sits between wide datapath stages (e.g. measurement/prediction result packers) and narrow stdcore_rfifo inputs, and drives their p/p_val/p_rdy interface directly. Its c/c_val/c_rdy port connects straight to an rfifo's p/p_val/p_rdy.

## Interface
Parameters:
- DW, 8, beat width in bits
- N, 4, maximum beats per word (N >= 1)
- LW, 3, width of p_len; must satisfy 2^LW > N

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- p  input  N*DW  wide word; beat k = p[k*DW +: DW], beat 0 sent first
- p_len  input  LW  beats to send, 1..N; 0 or >N is treated as N
- p_val  input  1  producer word valid
- p_rdy  output  1  serializer can accept a word this cycle
- c  output  DW  current beat
- c_last  output  1  current beat is the final beat of its word
- c_val  output  1  beat valid
- c_rdy  input  1  consumer ready

## Operation
- State: holding register hold[N*DW], beat index idx[LW], effective length len[LW], busy flag.
- Accept: p_val && p_rdy.
  - Load hold=p, len=eff(p_len), idx=0, busy=1.
- Emit:
  - c = hold[idx*DW +: DW]
  - c_val = busy
  - c_last = busy && (idx == len-1)
- Beat transfer: c_val && c_rdy.
  - If not last: idx+1.
  - If last and no accept in the same cycle: busy=0.
  - If last with an accept in the same cycle: reload from p, idx=0, busy stays 1.
- p_rdy = !rst && (!busy || (c_rdy && c_last)). This path is combinational from c_rdy; there is no registered-ready option.
- Data stability: c, c_last and c_val hold steady while c_val && !c_rdy. No beat is dropped or repeated.
- len=1 words: every beat is last, and back-to-back acceptance gives one beat per cycle.
- hold contents are don't-care when busy=0, but c must read 0 after reset until the first accept.
- Reset (rst=1 at an edge):
  - busy=0, idx=0, len=0, hold=0.
  - Outputs after that edge: c_val=0, c_last=0, c=0.
  - p_rdy=0 combinationally while rst=1, and p_rdy=1 in the first cycle after reset deasserts.
- Reset mid-word: the partially sent word is discarded with no further beats. Any p_val presented during rst is not accepted.

## Timing
- Latency: a word accepted at edge t presents beat 0 with c_val=1 in the cycle following t.
- Beats: one beat per cycle while c_rdy=1. A word of L beats occupies the output for L cycles.
- Back-to-back: the last beat of word A and the acceptance of word B at the same edge means beat 0 of B appears in the next cycle, with zero bubbles. Sustained throughput is 1 beat/cycle.
- Idle: busy=0 gives p_rdy=1 regardless of c_rdy.
- Busy and not on the last beat gives p_rdy=0 regardless of c_rdy.
- c_val has no combinational dependence on c_rdy or p_val, so it is safe to drive an rfifo whose p_rdy depends on its state.

## Test plan
1. Reset/idle:
   - Hold rst=1 for 3 cycles with p_val=1: p_rdy=0, c_val=0, c=0, and no word is accepted.
   - Release rst: p_rdy=1.
2. Full word, DW=8, N=4, c_rdy=1:
   - Stimulus: p=0x44332211, p_len=4.
   - Required: c = 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting the cycle after accept, with c_last only on 0x44.
3. Short words and length saturation:
   - p_len=1 with p=0x..AA gives a single beat 0xAA with c_last=1.
   - p_len=0 and p_len=7 each give 4 beats.
4. Back-pressure:
   - Same word as test 2, with c_rdy toggled 1,0,0,1,0,1,1.
   - Required: each beat is held stable while stalled, exactly 4 transfers occur in order, and p_rdy=0 until the cycle c_last && c_rdy.
5. Back-to-back streaming:
   - Stimulus: 100 random words with random p_len, p_val=1 continuously, c_rdy=1.
   - Required: no idle cycle between words, and the total number of c transfers equals the sum of the effective lengths.
   - A scoreboard matches every beat in order.
6. Reset mid-word:
   - Assert rst for 1 cycle after beat 1 of a 4-beat word.
   - Required: c_val=0 the next cycle, beats 2 and 3 are never emitted, and the next accepted word starts at beat 0.
